// File: rtl/ioaddr.sv
// I/O address map shared by the CPU-side peripherals.
// Endpoint register addresses live here, not in the endpoint package.
package ioaddr;
    localparam logic [15:0] ENDPI0_DATA   = 16'h5000;
    localparam logic [15:0] ENDPI0_STATUS = 16'h5002;
endpackage

// File: rtl/usb_endp_pkg.sv
// Shared types for the USB IN endpoint: FSM states and
// STATUS register bit positions.
package usb_endp_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SEND,
        ST_WAIT_ACK
    } ep_state_e;

    // STATUS read fields
    localparam int SB_ARMED  = 0;
    localparam int SB_TOGGLE = 1;
    localparam int SB_STALL  = 2;
    localparam int SB_FULL   = 3;
    localparam int SB_CNT    = 4;

    // STATUS write controls
    localparam int CB_ARM    = 0;
    localparam int CB_STALL  = 2;
    localparam int CB_FLUSH  = 3;

    function automatic logic [15:0] status_word(
        input logic [3:0] cnt,
        input logic       full,
        input logic       stall,
        input logic       toggle,
        input logic       armed
    );
        logic [15:0] w;
        w               = 16'h0;
        w[SB_ARMED]     = armed;
        w[SB_TOGGLE]    = toggle;
        w[SB_STALL]     = stall;
        w[SB_FULL]      = full;
        w[SB_CNT +: 4]  = cnt;
        return w;
    endfunction
endpackage

// File: rtl/usb_endpi_if.sv
// Signal bundle between an endpoint and its CPU/SIE environment.
// master = CPU+SIE side, slave = endpoint side.
interface usb_endpi_if;
    logic [15:0] io_addr;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_din;
    logic [15:0] io_dout;
    logic        in_token;
    logic        setup_rx;
    logic        ack_rx;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_zlp;
    logic        tx_pid1;
    logic        tx_ready;
    logic        hs_nak;
    logic        hs_stall;

    modport master (
        output io_addr, io_wr, io_rd, io_din,
        output in_token, setup_rx, ack_rx, tx_ready,
        input  io_dout, tx_valid, tx_data, tx_last,
        input  tx_zlp, tx_pid1, hs_nak, hs_stall
    );

    modport slave (
        input  io_addr, io_wr, io_rd, io_din,
        input  in_token, setup_rx, ack_rx, tx_ready,
        output io_dout, tx_valid, tx_data, tx_last,
        output tx_zlp, tx_pid1, hs_nak, hs_stall
    );
endinterface

// File: rtl/usb_pktbuf.sv
// Packet byte store: synchronous write, asynchronous read.
// Contents are not reset.
module usb_pktbuf #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // byte write from the CPU port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/usb_endpi.sv
// USB IN endpoint: CPU loads a packet, arms it, and the FSM
// streams it to the SIE with DATA0/DATA1 toggling and retry.
module usb_endpi
    import usb_endp_pkg::*;
#(
    parameter logic [15:0] DATA_ADDR   = ioaddr::ENDPI0_DATA,
    parameter logic [15:0] STATUS_ADDR = ioaddr::ENDPI0_STATUS,
    parameter int          MAXPKT      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_din,
    output logic [15:0] io_dout,
    input  logic        in_token,
    input  logic        setup_rx,
    input  logic        ack_rx,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        tx_zlp,
    output logic        tx_pid1,
    input  logic        tx_ready,
    output logic        hs_nak,
    output logic        hs_stall
);
    localparam int AW = $clog2(MAXPKT);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAXPKT);

    ep_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          toggle_q, toggle_d;
    logic          stall_q, stall_d;
    logic [15:0]   dout_q, dout_d;
    logic          nak_q, nak_d;
    logic          stl_q, stl_d;
    logic          zlp_q, zlp_d;

    logic          data_wr, stat_wr, stat_rd;
    logic          buf_we, sending, go;
    logic [7:0]    buf_rdata, cnt8;
    logic          unused_bits;

    assign data_wr = io_wr && (io_addr == DATA_ADDR);
    assign stat_wr = io_wr && (io_addr == STATUS_ADDR);
    assign stat_rd = io_rd && (io_addr == STATUS_ADDR);
    assign sending = (state_q == ST_SEND);
    assign go      = in_token && !stall_q;
    assign cnt8    = 8'(count_q);

    assign unused_bits = ^{io_din[15:4], io_din[1], cnt8[7:4]};

    usb_pktbuf #(.DEPTH(MAXPKT), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (count_q[AW-1:0]),
        .wdata (io_din[7:0]),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    assign tx_valid = sending;
    assign tx_data  = sending ? buf_rdata : 8'h0;
    assign tx_last  = sending && ({1'b0, rd_idx_q} == count_q - CW'(1));
    assign tx_pid1  = toggle_q;
    assign tx_zlp   = zlp_q;
    assign hs_nak   = nak_q;
    assign hs_stall = stl_q;
    assign io_dout  = dout_q;

    // next state, buffer write and handshake pulses
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        toggle_d = toggle_q;
        stall_d  = stall_q;
        nak_d    = 1'b0;
        stl_d    = 1'b0;
        zlp_d    = 1'b0;
        buf_we   = 1'b0;
        dout_d   = stat_rd ? status_word(cnt8[3:0],
                                         count_q == FULL_CNT,
                                         stall_q, toggle_q,
                                         state_q != ST_IDLE)
                           : 16'h0;
        if (setup_rx) begin
            // control transfer restart overrides everything else
            toggle_d = 1'b1;
            stall_d  = 1'b0;
            count_d  = '0;
            state_d  = ST_IDLE;
        end else begin
            if (stat_wr) stall_d = io_din[CB_STALL];
            if (in_token && stall_q) stl_d = 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (go) nak_d = 1'b1;
                    if (data_wr && count_q < FULL_CNT) begin
                        buf_we  = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    if (stat_wr && io_din[CB_FLUSH]) count_d = '0;
                    if (stat_wr && io_din[CB_ARM]) state_d = ST_ARMED;
                end
                ST_ARMED, ST_WAIT_ACK: begin
                    if (state_q == ST_WAIT_ACK && ack_rx) begin
                        toggle_d = ~toggle_q;
                        count_d  = '0;
                        state_d  = ST_IDLE;
                    end else if (go) begin
                        // first try or host retry after a lost ACK
                        if (count_q == '0) begin
                            zlp_d   = 1'b1;
                            state_d = ST_WAIT_ACK;
                        end else begin
                            rd_idx_d = '0;
                            state_d  = ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        rd_idx_d = rd_idx_q + AW'(1);
                        if (tx_last) state_d = ST_WAIT_ACK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rd_idx_q <= '0;
            toggle_q <= 1'b0;
            stall_q  <= 1'b0;
            dout_q   <= 16'h0;
            nak_q    <= 1'b0;
            stl_q    <= 1'b0;
            zlp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            toggle_q <= toggle_d;
            stall_q  <= stall_d;
            dout_q   <= dout_d;
            nak_q    <= nak_d;
            stl_q    <= stl_d;
            zlp_q    <= zlp_d;
        end
    end
endmodule

// File: tb/tb_usb_endpi.sv
// Self-checking bench for usb_endpi: scenario tasks with a
// byte scoreboard for transmitted packets.
module tb_usb_endpi;
    localparam logic [15:0] DATA = 16'h5000;
    localparam logic [15:0] STAT = 16'h5002;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_endpi_if bus();

    usb_endpi dut (
        .clk      (clk),
        .reset    (reset),
        .io_addr  (bus.io_addr),
        .io_wr    (bus.io_wr),
        .io_rd    (bus.io_rd),
        .io_din   (bus.io_din),
        .io_dout  (bus.io_dout),
        .in_token (bus.in_token),
        .setup_rx (bus.setup_rx),
        .ack_rx   (bus.ack_rx),
        .tx_valid (bus.tx_valid),
        .tx_data  (bus.tx_data),
        .tx_last  (bus.tx_last),
        .tx_zlp   (bus.tx_zlp),
        .tx_pid1  (bus.tx_pid1),
        .tx_ready (bus.tx_ready),
        .hs_nak   (bus.hs_nak),
        .hs_stall (bus.hs_stall)
    );

    int vecs = 0;
    int errs = 0;
    logic [7:0] exp_q[$];
    logic [15:0] st;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.io_addr  = 16'h0;
        bus.io_wr    = 1'b0;
        bus.io_rd    = 1'b0;
        bus.io_din   = 16'h0;
        bus.in_token = 1'b0;
        bus.setup_rx = 1'b0;
        bus.ack_rx   = 1'b0;
        bus.tx_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_addr = a;
        bus.io_din  = d;
        bus.io_wr   = 1'b1;
        step();
        bus.io_wr   = 1'b0;
    endtask

    task automatic load(input logic [7:0] b, input bit stored);
        cpu_wr(DATA, {8'h0, b});
        if (stored) exp_q.push_back(b);
    endtask

    task automatic status_rd(output logic [15:0] v);
        bus.io_addr = STAT;
        bus.io_rd   = 1'b1;
        step();
        bus.io_rd   = 1'b0;
        v = bus.io_dout;
    endtask

    task automatic pulse_token();
        bus.in_token = 1'b1;
        step();
        bus.in_token = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack_rx = 1'b1;
        step();
        bus.ack_rx = 1'b0;
    endtask

    task automatic check_status(input string nm, input logic [15:0] exp);
        status_rd(st);
        vecs++;
        if (st !== exp) begin
            errs++;
            $display("FAIL %s: status got %h want %h", nm, st, exp);
        end
    endtask

    // drain one packet with tx_ready high, comparing against exp_q
    task automatic send_pkt(input string nm, input logic pid);
        logic [7:0] e;
        bit done;
        done = 1'b0;
        bus.tx_ready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.tx_valid) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL %s: extra byte %h", nm, bus.tx_data);
                    e = 8'hxx;
                end else begin
                    e = exp_q.pop_front();
                end
                if (bus.tx_data !== e || bus.tx_pid1 !== pid ||
                    bus.tx_last !== (exp_q.size() == 0)) begin
                    errs++;
                    $display("FAIL %s: data/pid/last got %h/%b/%b want %h/%b/%b",
                             nm, bus.tx_data, bus.tx_pid1, bus.tx_last,
                             e, pid, exp_q.size() == 0);
                end
                if (bus.tx_last) done = 1'b1;
            end
            step();
        end
        bus.tx_ready = 1'b0;
        vecs++;
        if (!done || exp_q.size() != 0 || bus.tx_valid !== 1'b0) begin
            errs++;
            $display("FAIL %s: end of packet done=%b left=%0d valid=%b want 1/0/0",
                     nm, done, exp_q.size(), bus.tx_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (bus.io_dout !== 16'h0 || bus.tx_valid !== 1'b0 ||
            bus.tx_zlp !== 1'b0 || bus.hs_nak !== 1'b0 ||
            bus.hs_stall !== 1'b0 || bus.tx_pid1 !== 1'b0) begin
            errs++;
            $display("FAIL reset_outs: dout=%h v=%b z=%b n=%b s=%b p=%b want all 0",
                     bus.io_dout, bus.tx_valid, bus.tx_zlp,
                     bus.hs_nak, bus.hs_stall, bus.tx_pid1);
        end
        check_status("reset_status", 16'h0000);
        load(8'h5a, 1'b1);
        bus.io_addr = DATA;
        bus.io_rd   = 1'b1;
        step();
        bus.io_rd   = 1'b0;
        vecs++;
        if (bus.io_dout !== 16'h0) begin
            errs++;
            $display("FAIL data_read: got %h want 0000", bus.io_dout);
        end
    endtask

    task automatic test_basic();
        do_reset();
        load(8'h11, 1'b1);
        load(8'h22, 1'b1);
        load(8'h33, 1'b1);
        check_status("basic_loaded", 16'h0030);
        cpu_wr(STAT, 16'h0001);
        pulse_token();
        send_pkt("basic_pkt", 1'b0);
        pulse_ack();
        check_status("basic_acked", 16'h0002);
    endtask

    task automatic test_zlp();
        do_reset();
        cpu_wr(STAT, 16'h0001);
        check_status("zlp_armed", 16'h0001);
        pulse_token();
        vecs++;
        if (bus.tx_zlp !== 1'b1 || bus.tx_pid1 !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errs++;
            $display("FAIL zlp_pulse: zlp/pid/valid got %b/%b/%b want 1/0/0",
                     bus.tx_zlp, bus.tx_pid1, bus.tx_valid);
        end
        step();
        vecs++;
        if (bus.tx_zlp !== 1'b0) begin
            errs++;
            $display("FAIL zlp_width: got %b want 0", bus.tx_zlp);
        end
        pulse_ack();
        check_status("zlp_acked", 16'h0002);
    endtask

    task automatic test_retry();
        do_reset();
        load(8'hc3, 1'b1);
        load(8'h7e, 1'b1);
        cpu_wr(STAT, 16'h0001);
        pulse_token();
        send_pkt("retry_first", 1'b0);
        exp_q.push_back(8'hc3);
        exp_q.push_back(8'h7e);
        pulse_token();
        send_pkt("retry_again", 1'b0);
        pulse_ack();
        check_status("retry_acked", 16'h0002);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            load(8'(8'h40 + i), i < 8);
        end
        check_status("full_status", 16'h0088);
        cpu_wr(STAT, 16'h0001);
        pulse_token();
        send_pkt("full_pkt", 1'b0);
        pulse_ack();
    endtask

    task automatic test_stall();
        do_reset();
        cpu_wr(STAT, 16'h0004);
        check_status("stall_set", 16'h0004);
        pulse_token();
        vecs++;
        if (bus.hs_stall !== 1'b1 || bus.hs_nak !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errs++;
            $display("FAIL stall_pulse: stall/nak/valid got %b/%b/%b want 1/0/0",
                     bus.hs_stall, bus.hs_nak, bus.tx_valid);
        end
        step();
        vecs++;
        if (bus.hs_stall !== 1'b0) begin
            errs++;
            $display("FAIL stall_width: got %b want 0", bus.hs_stall);
        end
        bus.setup_rx = 1'b1;
        step();
        bus.setup_rx = 1'b0;
        check_status("stall_setup", 16'h0002);
    endtask

    task automatic test_nak();
        do_reset();
        pulse_token();
        vecs++;
        if (bus.hs_nak !== 1'b1 || bus.hs_stall !== 1'b0) begin
            errs++;
            $display("FAIL nak_pulse: nak/stall got %b/%b want 1/0",
                     bus.hs_nak, bus.hs_stall);
        end
        step();
        vecs++;
        if (bus.hs_nak !== 1'b0) begin
            errs++;
            $display("FAIL nak_width: got %b want 0", bus.hs_nak);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        load(8'h9a, 1'b1);
        load(8'hbc, 1'b1);
        load(8'hde, 1'b1);
        cpu_wr(STAT, 16'h0001);
        pulse_token();
        vecs++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[0]) begin
            errs++;
            $display("FAIL midsend_first: valid/data got %b/%h want 1/%h",
                     bus.tx_valid, bus.tx_data, exp_q[0]);
        end
        reset = 1'b1;
        step();
        vecs++;
        if (bus.tx_valid !== 1'b0) begin
            errs++;
            $display("FAIL midsend_drop: tx_valid got %b want 0", bus.tx_valid);
        end
        reset = 1'b0;
        exp_q.delete();
        check_status("midsend_status", 16'h0000);
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(8'h01, 1'b0);
        load(8'h02, 1'b0);
        cpu_wr(STAT, 16'h0008);
        check_status("b2b_flush", 16'h0000);
        load(8'ha1, 1'b1);
        load(8'ha2, 1'b1);
        cpu_wr(STAT, 16'h0001);
        load(8'hee, 1'b0);
        check_status("b2b_armed_wr", 16'h0021);
        pulse_token();
        send_pkt("b2b_pkt0", 1'b0);
        pulse_ack();
        load(8'hb7, 1'b1);
        cpu_wr(STAT, 16'h0001);
        pulse_token();
        send_pkt("b2b_pkt1", 1'b1);
        pulse_ack();
        check_status("b2b_final", 16'h0000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zlp();
        test_retry();
        test_full();
        test_stall();
        test_nak();
        test_reset_mid_send();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/usb_endpi.md
USB_ENDPI -- requirements
Module: usb_endpi

Interface
REQ-001 SHALL have parameter DATA_ADDR, default 16'h5000 (ioaddr::ENDPI0_DATA), CPU byte-write port address.
REQ-002 SHALL have parameter STATUS_ADDR, default 16'h5002 (ioaddr::ENDPI0_STATUS), status/control register address.
REQ-003 SHALL have parameter MAXPKT, default 8, packet buffer depth in bytes (power of two, 8..64).
REQ-004 Ports, in order:
 clk  in  1  single clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 io_addr  in  16  CPU I/O address
 io_wr  in  1  CPU write strobe, one cycle
 io_rd  in  1  CPU read strobe, one cycle
 io_din  in  16  CPU write data
 io_dout  out  16  CPU read data
 in_token  in  1  one-cycle pulse: IN token addressed to this endpoint
 setup_rx  in  1  one-cycle pulse: SETUP token received on this endpoint
 ack_rx  in  1  one-cycle pulse: host ACK after our data packet
 tx_valid  out  1  byte available to SIE transmitter
 tx_data  out  8  byte to transmit
 tx_last  out  1  qualifies final byte of packet
 tx_zlp  out  1  one-cycle pulse: send zero-length packet
 tx_pid1  out  1  data toggle for current packet (0=DATA0, 1=DATA1)
 tx_ready  in  1  SIE accepts tx_data when tx_valid && tx_ready
 hs_nak  out  1  one-cycle pulse: answer NAK
 hs_stall  out  1  one-cycle pulse: answer STALL

Function
REQ-005 CPU write to DATA_ADDR in state IDLE with count<MAXPKT SHALL store io_din[7:0] at buf[count], count+1; otherwise write ignored, count unchanged.
REQ-006 STATUS write SHALL act on io_din: bit0=1 arm (IDLE->ARMED), bit2 sets stall flag to its value, bit3=1 flush (count=0, only in IDLE).
REQ-007 STATUS read SHALL return {8'h0, count[3:0], full, stall, toggle, armed} where armed=1 in ARMED/SEND/WAIT_ACK; full = count==MAXPKT.
REQ-008 io_dout SHALL be registered: valid the cycle after io_rd with matching address, 16'h0 otherwise; DATA_ADDR reads return 16'h0.
REQ-009 FSM states IDLE, ARMED, SEND, WAIT_ACK.
REQ-010 in_token with stall=1 SHALL pulse hs_stall next cycle in any state, no other effect.
REQ-011 IDLE + in_token (stall=0) SHALL pulse hs_nak next cycle.
REQ-012 ARMED + in_token: count=0 -> tx_zlp pulse next cycle, go WAIT_ACK; else rd_idx=0, go SEND.
REQ-013 SEND: tx_valid=1, tx_data=buf[rd_idx], tx_last=(rd_idx==count-1); each handshake rd_idx+1; handshake with tx_last -> WAIT_ACK.
REQ-014 tx_pid1 SHALL equal toggle throughout SEND and the tx_zlp cycle.
REQ-015 WAIT_ACK + ack_rx: toggle inverts, count=0, go IDLE (armed clears).
REQ-016 WAIT_ACK + in_token (host retry, lost ACK): retransmit same packet, same toggle, rd_idx=0, behave as REQ-012.
REQ-017 setup_rx in any state SHALL set toggle=1, clear stall, count=0, go IDLE; priority over in_token, ack_rx and CPU writes in the same cycle.
REQ-018 ack_rx outside WAIT_ACK and in_token during SEND SHALL be ignored.
REQ-019 CPU write to STATUS with arm during ARMED/SEND/WAIT_ACK ignored; stall bit still applied.

Reset
REQ-020 On reset: state IDLE, count=0, rd_idx=0, toggle=0, stall=0, io_dout=0, all tx_*/hs_* outputs 0; buffer contents undefined.
REQ-021 Reset mid-SEND SHALL drop tx_valid the following cycle.

Structure
REQ-022 FSM state enum and STATUS bit positions SHALL live in package usb_endp_pkg; addresses stay in package ioaddr.
REQ-023 Packet storage SHALL be one sub-module usb_pktbuf (MAXPKT x 8, sync write, async read).

Verification
REQ-024 Write 3 bytes 11,22,33, arm, in_token, tx_ready=1 -> tx_data 11,22,33, tx_last on 33, tx_pid1=0; ack_rx -> STATUS reads 16'h0002.
REQ-025 Arm with count=0, in_token -> tx_zlp one pulse; ack_rx -> toggle=1.
REQ-026 Load 2 bytes, arm, send, in_token instead of ack_rx -> identical 2 bytes, same tx_pid1.
REQ-027 Write 9 bytes with MAXPKT=8 -> STATUS count=8, full=1; 9th byte absent on transmit.
REQ-028 STATUS write 16'h0004, in_token -> hs_stall pulse, no tx_valid; setup_rx -> stall=0, toggle=1.
REQ-029 in_token in IDLE -> hs_nak; reset asserted mid-SEND -> tx_valid 0 next cycle, STATUS 16'h0000.
